// File: rtl/fir_coef_set_ctrl_if.sv
// Coefficient ROM read port and FIR tap-write handshake.
// master = set controller, slave = ROM + FIR tap bank.
interface fir_coef_set_ctrl_if #(
    parameter int SET_W  = 2,
    parameter int TAP_W  = 4,
    parameter int COEF_W = 16
);
    logic [SET_W+TAP_W-1:0] coef_rom_addr;
    logic [COEF_W-1:0]      coef_rom_data;
    logic                   coef_wr_en;
    logic [TAP_W-1:0]       coef_wr_idx;
    logic [COEF_W-1:0]      coef_wr_data;
    logic                   coef_wr_ready;

    modport master (
        output coef_rom_addr,
        input  coef_rom_data,
        output coef_wr_en,
        output coef_wr_idx,
        output coef_wr_data,
        input  coef_wr_ready
    );

    modport slave (
        input  coef_rom_addr,
        output coef_rom_data,
        input  coef_wr_en,
        input  coef_wr_idx,
        input  coef_wr_data,
        output coef_wr_ready
    );
endinterface

// File: rtl/fir_coef_set_ctrl.sv
// FIR coefficient set selector: button pulses pick a set, which is
// streamed from ROM into the FIR taps with the filter held disabled.
module fir_coef_set_ctrl #(
    parameter int NUM_SETS = 4,
    parameter int SET_W    = 2,
    parameter int NUM_TAPS = 16,
    parameter int TAP_W    = 4,
    parameter int COEF_W   = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic             next_pulse,
    input  logic             prev_pulse,
    input  logic             bypass_pulse,
    fir_coef_set_ctrl_if.master bus,
    output logic             fir_enable,
    output logic             fir_bypass,
    output logic [SET_W-1:0] active_set,
    output logic             busy,
    output logic             load_done,
    output logic             load_error
);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [SET_W+TAP_W-1:0] addr_q, addr_d;
    logic                   wr_en_q, wr_en_d;
    logic [TAP_W-1:0]       wr_idx_q, wr_idx_d;
    logic [COEF_W-1:0]      wr_data_q, wr_data_d;
    logic                   fir_en_q, fir_en_d;
    logic                   bypass_q, bypass_d;
    logic [SET_W-1:0]       active_q, active_d;
    logic                   error_q, error_d;
    logic                   init_req_q, init_req_d;
    logic [SET_W-1:0]       pending_q, pending_d;
    logic [TAP_W-1:0]       tap_q, tap_d;
    logic [TMR_W-1:0]       timer_q, timer_d;

    logic last_tap;
    logic timer_exp;

    assign last_tap  = (tap_q == TAP_W'(NUM_TAPS - 1));
    assign timer_exp = (timer_q == TMR_W'(TIMEOUT - 1));

    // FSM state register
    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath updates; bypass toggles independently of the FSM
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_en_d    = wr_en_q;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        fir_en_d   = fir_en_q;
        active_d   = active_q;
        error_d    = error_q;
        init_req_d = init_req_q;
        pending_d  = pending_q;
        tap_d      = tap_q;
        timer_d    = timer_q;
        bypass_d   = bypass_pulse ? ~bypass_q : bypass_q;

        unique case (state_q)
            S_IDLE: begin
                if (init_req_q) begin
                    init_req_d = 1'b0;
                    pending_d  = '0;
                    tap_d      = '0;
                    fir_en_d   = 1'b0;
                    state_d    = S_RD;
                end else if (next_pulse && !prev_pulse) begin
                    pending_d = active_q + SET_W'(1);
                    tap_d     = '0;
                    fir_en_d  = 1'b0;
                    state_d   = S_RD;
                end else if (prev_pulse && !next_pulse) begin
                    pending_d = active_q - SET_W'(1);
                    tap_d     = '0;
                    fir_en_d  = 1'b0;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                addr_d  = {pending_q, tap_q};
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wr_data_d = bus.coef_rom_data;
                wr_idx_d  = tap_q;
                wr_en_d   = 1'b1;
                timer_d   = '0;
                state_d   = S_WR;
            end
            S_WR: begin
                if (bus.coef_wr_ready) begin
                    wr_en_d = 1'b0;
                    if (last_tap) begin
                        state_d = S_DONE;
                    end else begin
                        tap_d   = tap_q + TAP_W'(1);
                        state_d = S_RD;
                    end
                end else if (timer_exp) begin
                    wr_en_d = 1'b0;
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                active_d = pending_q;
                fir_en_d = 1'b1;
                error_d  = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clk50) begin
        if (reset) begin
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            fir_en_q   <= 1'b0;
            bypass_q   <= 1'b0;
            active_q   <= '0;
            error_q    <= 1'b0;
            init_req_q <= 1'b1;
            pending_q  <= '0;
            tap_q      <= '0;
            timer_q    <= '0;
        end else begin
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            fir_en_q   <= fir_en_d;
            bypass_q   <= bypass_d;
            active_q   <= active_d;
            error_q    <= error_d;
            init_req_q <= init_req_d;
            pending_q  <= pending_d;
            tap_q      <= tap_d;
            timer_q    <= timer_d;
        end
    end

    assign bus.coef_rom_addr = addr_q;
    assign bus.coef_wr_en    = wr_en_q;
    assign bus.coef_wr_idx   = wr_idx_q;
    assign bus.coef_wr_data  = wr_data_q;

    assign fir_enable = fir_en_q;
    assign fir_bypass = bypass_q;
    assign active_set = active_q;
    assign load_error = error_q;
    assign busy       = (state_q != S_IDLE);
    assign load_done  = (state_q == S_DONE);
endmodule

// File: tb/tb_fir_coef_set_ctrl.sv
// Directed bench for fir_coef_set_ctrl: ROM model, FIR write
// monitor and hand-computed expectations for each load scenario.
module tb_fir_coef_set_ctrl;
    logic       clk50;
    logic       reset;
    logic       next_pulse;
    logic       prev_pulse;
    logic       bypass_pulse;
    logic       fir_enable;
    logic       fir_bypass;
    logic [1:0] active_set;
    logic       busy;
    logic       load_done;
    logic       load_error;

    fir_coef_set_ctrl_if #(.SET_W(2), .TAP_W(4), .COEF_W(16)) bus ();

    fir_coef_set_ctrl dut (
        .clk50       (clk50),
        .reset       (reset),
        .next_pulse  (next_pulse),
        .prev_pulse  (prev_pulse),
        .bypass_pulse(bypass_pulse),
        .bus         (bus.master),
        .fir_enable  (fir_enable),
        .fir_bypass  (fir_bypass),
        .active_set  (active_set),
        .busy        (busy),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    initial clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    logic [15:0] rom [64];
    assign bus.coef_rom_data = rom[bus.coef_rom_addr];

    int n_cmp = 0;
    int n_bad = 0;

    // ready driver: optional stall on one tap, or held low for timeout
    logic hold_low = 1'b0;
    logic stall_en = 1'b0;
    int   st_cnt   = 0;
    always @(posedge clk50) begin
        #1;
        if (!stall_en) st_cnt = 0;
        if (stall_en && bus.coef_wr_en && bus.coef_wr_idx == 4'd7 && st_cnt < 5) begin
            bus.coef_wr_ready = 1'b0;
            st_cnt++;
        end else begin
            bus.coef_wr_ready = !hold_low;
        end
    end

    // write monitor: accepted writes, stalled cycles, stability while stalled
    int          wq_idx[$];
    logic [15:0] wq_dat[$];
    int          stall_cyc = 0;
    int          unstable  = 0;
    logic        p_wait    = 1'b0;
    logic [3:0]  p_idx     = '0;
    logic [15:0] p_dat     = '0;
    always @(negedge clk50) begin
        if (bus.coef_wr_en && bus.coef_wr_ready) begin
            wq_idx.push_back(int'(bus.coef_wr_idx));
            wq_dat.push_back(bus.coef_wr_data);
        end
        if (p_wait && bus.coef_wr_en &&
            (bus.coef_wr_idx != p_idx || bus.coef_wr_data != p_dat))
            unstable++;
        if (bus.coef_wr_en && !bus.coef_wr_ready) stall_cyc++;
        p_wait = bus.coef_wr_en && !bus.coef_wr_ready;
        p_idx  = bus.coef_wr_idx;
        p_dat  = bus.coef_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input int kind);
        @(posedge clk50) #1;
        next_pulse = (kind == 0 || kind == 2);
        prev_pulse = (kind == 1 || kind == 2);
        @(posedge clk50) #1;
        next_pulse = 1'b0;
        prev_pulse = 1'b0;
    endtask

    // counts posedges until load_done is seen; -1 on budget expiry
    task automatic wait_done(input int max, input int bp_at, output int n);
        int k;
        k = 0;
        n = -1;
        while (k < max) begin
            @(posedge clk50);
            k++;
            #1 bypass_pulse = (k == bp_at);
            @(negedge clk50);
            if (load_done) begin
                n = k;
                break;
            end
        end
        bypass_pulse = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int base, input int set);
        check({tag, "_n"}, wq_idx.size() - base, 16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < wq_idx.size()) begin
                check({tag, "_idx"}, wq_idx[base+i], i);
                check({tag, "_dat"}, wq_dat[base+i], rom[set*16+i]);
            end
        end
    endtask

    initial begin
        int n;
        int base;
        int s0;
        int bsy;

        for (int i = 0; i < 64; i++) rom[i] = 16'h1000 + 16'(i * 257);
        bus.coef_wr_ready = 1'b1;
        reset        = 1'b1;
        next_pulse   = 1'b0;
        prev_pulse   = 1'b0;
        bypass_pulse = 1'b0;

        repeat (3) @(posedge clk50);
        @(negedge clk50);
        check("rst_addr", bus.coef_rom_addr, 0);
        check("rst_wren", bus.coef_wr_en, 0);
        check("rst_idx", bus.coef_wr_idx, 0);
        check("rst_data", bus.coef_wr_data, 0);
        check("rst_stat", {fir_enable, fir_bypass, busy, load_done, load_error}, 0);
        check("rst_set", active_set, 0);

        // initial load of set 0 after reset release
        @(posedge clk50) #1 reset = 1'b0;
        base = wq_idx.size();
        wait_done(100, 0, n);
        check("init_lat", n, 49);
        check_writes("init", base, 0);
        @(negedge clk50);
        check("init_en", fir_enable, 1);
        check("init_set", active_set, 0);
        check("init_busy", busy, 0);

        // prev from set 0 wraps to set 3
        base = wq_idx.size();
        pulse(1);
        wait_done(100, 0, n);
        check("prev_lat", n, 48);
        check_writes("prev", base, 3);
        @(negedge clk50);
        check("prev_set", active_set, 3);
        check("prev_en", fir_enable, 1);

        // next from set 3 wraps to set 0
        base = wq_idx.size();
        pulse(0);
        wait_done(100, 0, n);
        check_writes("next", base, 0);
        @(negedge clk50);
        check("next_set", active_set, 0);

        // next and prev together are ignored
        base = wq_idx.size();
        pulse(2);
        bsy = 0;
        repeat (6) begin
            @(negedge clk50);
            if (busy) bsy++;
        end
        check("both_busy", bsy, 0);
        check("both_set", active_set, 0);
        check("both_nwr", wq_idx.size() - base, 0);

        // ready low for 5 cycles on tap 7
        stall_en = 1'b1;
        base = wq_idx.size();
        s0 = stall_cyc;
        pulse(0);
        wait_done(100, 0, n);
        stall_en = 1'b0;
        check("stall_cyc", stall_cyc - s0, 5);
        check("stall_stab", unstable, 0);
        check("stall_lat", n, 53);
        check_writes("stall", base, 1);
        @(negedge clk50);
        check("stall_set", active_set, 1);

        // ready held low: timeout after 1024 WR cycles
        hold_low = 1'b1;
        s0 = stall_cyc;
        pulse(0);
        n = -1;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk50);
            if (load_error) begin
                n = k;
                break;
            end
        end
        check("to_seen", n >= 0, 1);
        check("to_cyc", stall_cyc - s0, 1024);
        check("to_en", fir_enable, 0);
        check("to_set", active_set, 1);
        check("to_busy", busy, 0);
        check("to_wren", bus.coef_wr_en, 0);
        hold_low = 1'b0;

        // successful load clears the error; bypass toggles mid-load
        base = wq_idx.size();
        pulse(0);
        wait_done(100, 10, n);
        check("clr_lat", n, 48);
        check("bp_on", fir_bypass, 1);
        check_writes("clr", base, 2);
        @(negedge clk50);
        check("clr_err", load_error, 0);
        check("clr_set", active_set, 2);
        check("clr_en", fir_enable, 1);

        // reset while tap 9 is being written
        pulse(0);
        n = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk50);
            if (bus.coef_wr_en && bus.coef_wr_idx == 4'd9) begin
                n = k;
                break;
            end
        end
        check("mid_t9", n >= 0, 1);
        @(posedge clk50) #1 reset = 1'b1;
        @(posedge clk50) #1 reset = 1'b0;
        base = wq_idx.size();
        @(negedge clk50);
        check("mid_wren", bus.coef_wr_en, 0);
        check("mid_stat", {fir_enable, fir_bypass, busy, load_error}, 0);
        check("mid_set", active_set, 0);
        wait_done(100, 0, n);
        check("mid_lat", n, 49);
        check_writes("mid", base, 0);
        @(negedge clk50);
        check("mid_en", fir_enable, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
